// File: rtl/life_grid_engine.sv
// Game of Life engine: double-buffered cell grid, configurable birth/survive rule,
// toroidal or dead-border edges, host seeding and a registered scaled-pixel lookup.
module life_grid_engine #(
    parameter int unsigned COLS        = 32,
    parameter int unsigned ROWS        = 24,
    parameter int unsigned CELL_SHIFT  = 4,
    parameter bit          WRAP        = 1'b1,
    parameter logic [8:0]  BIRTH       = 9'b000001000,
    parameter logic [8:0]  SURVIVE     = 9'b000001100,
    parameter bit          SEED_GLIDER = 1'b1,
    parameter logic [2:0]  ALIVE_RGB   = 3'b111,
    parameter logic [2:0]  DEAD_RGB    = 3'b000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        vsync,
    input  logic        run,
    input  logic        step,
    input  logic        wr_en,
    input  logic [5:0]  wr_x,
    input  logic [5:0]  wr_y,
    input  logic        wr_val,
    input  logic [9:0]  VGAx,
    input  logic [9:0]  VGAy,
    output logic [2:0]  rgb,
    output logic        busy,
    output logic [15:0] gen_count
);
    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned IW    = $clog2(CELLS);

    typedef enum logic [1:0] {IDLE, CALC, SWAP} state_t;

    state_t            state;
    logic              sel;
    logic [CELLS-1:0]  plane [2];
    logic [5:0]        x_pos;
    logic [5:0]        y_pos;
    logic              step_flag;
    logic              vsync_q;
    logic              vsync_q2;

    function automatic logic [IW-1:0] idx_of(input int x, input int y);
        return IW'(y * int'(COLS) + x);
    endfunction

    function automatic logic [CELLS-1:0] seed_plane();
        logic [CELLS-1:0] p;
        int gx [5];
        int gy [5];
        gx = '{1, 2, 0, 1, 2};
        gy = '{0, 1, 2, 2, 2};
        p  = '0;
        for (int i = 0; i < 5; i++) begin
            if (gx[i] < int'(COLS) && gy[i] < int'(ROWS)) p[idx_of(gx[i], gy[i])] = 1'b1;
        end
        return p;
    endfunction

    // Live neighbours of (x,y) in plane p, honouring the edge mode.
    function automatic logic [3:0] count_nbrs(input logic [CELLS-1:0] p, input int x, input int y);
        logic [3:0] n;
        logic       live;
        int         nx;
        int         ny;
        n = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                live = 1'b0;
                nx   = x + dx;
                ny   = y + dy;
                if (dx != 0 || dy != 0) begin
                    if (WRAP) begin
                        nx   = (nx + int'(COLS)) % int'(COLS);
                        ny   = (ny + int'(ROWS)) % int'(ROWS);
                        live = p[idx_of(nx, ny)];
                    end else if (nx >= 0 && nx < int'(COLS) && ny >= 0 && ny < int'(ROWS)) begin
                        live = p[idx_of(nx, ny)];
                    end
                end
                n = n + 4'(live);
            end
        end
        return n;
    endfunction

    logic [CELLS-1:0] cur_plane;
    logic [IW-1:0]    cell_idx;
    logic [3:0]       nbrs;
    logic             next_val;
    logic             trigger;
    logic             wr_ok;
    logic [IW-1:0]    wr_idx;
    logic [9:0]       cx;
    logic [9:0]       cy;
    logic             pix_in;
    logic [IW-1:0]    pix_idx;
    logic [2:0]       pix_rgb;

    assign cur_plane = sel ? plane[1] : plane[0];
    assign cell_idx  = idx_of(int'(x_pos), int'(y_pos));
    assign nbrs      = count_nbrs(cur_plane, int'(x_pos), int'(y_pos));
    assign next_val  = cur_plane[cell_idx] ? SURVIVE[nbrs] : BIRTH[nbrs];
    assign trigger   = (run && vsync_q && !vsync_q2) || step || step_flag;
    assign wr_ok     = wr_en && (32'(wr_x) < COLS) && (32'(wr_y) < ROWS);
    assign wr_idx    = idx_of(int'(wr_x), int'(wr_y));
    assign cx        = VGAx >> CELL_SHIFT;
    assign cy        = VGAy >> CELL_SHIFT;
    assign pix_in    = (32'(cx) < COLS) && (32'(cy) < ROWS);
    assign pix_idx   = idx_of(int'(cx), int'(cy));
    assign pix_rgb   = (pix_in && cur_plane[pix_idx]) ? ALIVE_RGB : DEAD_RGB;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            sel       <= 1'b0;
            plane[0]  <= SEED_GLIDER ? seed_plane() : '0;
            plane[1]  <= '0;
            x_pos     <= '0;
            y_pos     <= '0;
            step_flag <= 1'b0;
            vsync_q   <= 1'b0;
            vsync_q2  <= 1'b0;
            rgb       <= 3'b000;
            busy      <= 1'b0;
            gen_count <= '0;
        end else begin
            vsync_q  <= vsync;
            vsync_q2 <= vsync_q;
            rgb      <= pix_rgb;
            if (step) step_flag <= 1'b1;
            case (state)
                IDLE: begin
                    if (wr_ok) plane[sel][wr_idx] <= wr_val;
                    if (trigger) begin
                        state     <= CALC;
                        busy      <= 1'b1;
                        x_pos     <= '0;
                        y_pos     <= '0;
                        step_flag <= 1'b0;
                    end
                end
                CALC: begin
                    plane[~sel][cell_idx] <= next_val;
                    if (x_pos == 6'(COLS - 1)) begin
                        x_pos <= '0;
                        if (y_pos == 6'(ROWS - 1)) state <= SWAP;
                        else                       y_pos <= y_pos + 6'd1;
                    end else begin
                        x_pos <= x_pos + 6'd1;
                    end
                end
                SWAP: begin
                    sel       <= ~sel;
                    gen_count <= gen_count + 16'd1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_life_grid_engine.sv
// Bench for life_grid_engine: a toroidal 8x8 B3/S23 instance and a dead-border
// 7x5 B36/S23 instance share stimulus and are checked against a cell-level model.
module tb_life_grid_engine;
    logic        clk;
    logic        clr;
    logic        vsync;
    logic        run;
    logic        step;
    logic        wr_en;
    logic [5:0]  wr_x;
    logic [5:0]  wr_y;
    logic        wr_val;
    logic [9:0]  VGAx;
    logic [9:0]  VGAy;
    logic [2:0]  rgb0;
    logic [2:0]  rgb1;
    logic        busy0;
    logic        busy1;
    logic [15:0] gen0;
    logic [15:0] gen1;

    int checks = 0;
    int errors = 0;

    life_grid_engine #(.COLS(8), .ROWS(8), .CELL_SHIFT(4), .WRAP(1'b1),
                       .BIRTH(9'b000001000), .SURVIVE(9'b000001100), .SEED_GLIDER(1'b1)) u0 (
        .clk(clk), .clr(clr), .vsync(vsync), .run(run), .step(step),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val),
        .VGAx(VGAx), .VGAy(VGAy), .rgb(rgb0), .busy(busy0), .gen_count(gen0));

    life_grid_engine #(.COLS(7), .ROWS(5), .CELL_SHIFT(4), .WRAP(1'b0),
                       .BIRTH(9'b001001000), .SURVIVE(9'b000001100), .SEED_GLIDER(1'b0)) u1 (
        .clk(clk), .clr(clr), .vsync(vsync), .run(run), .step(step),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val),
        .VGAx(VGAx), .VGAy(VGAy), .rgb(rgb1), .busy(busy1), .gen_count(gen1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain grids with rule tables.
    bit         mg [2][8][8];
    int         mcols [2]  = '{8, 7};
    int         mrows [2]  = '{8, 5};
    int         mwrap [2]  = '{1, 0};
    logic [8:0] mbirth [2] = '{9'b000001000, 9'b001001000};
    logic [8:0] msurv [2]  = '{9'b000001100, 9'b000001100};
    int         exp_gen [2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_gen[d] = 0;
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++) mg[d][y][x] = 1'b0;
        end
        mg[0][0][1] = 1'b1; mg[0][1][2] = 1'b1;
        mg[0][2][0] = 1'b1; mg[0][2][1] = 1'b1; mg[0][2][2] = 1'b1;
    endfunction

    function automatic void model_write(int x, int y, bit v);
        for (int d = 0; d < 2; d++)
            if (x < mcols[d] && y < mrows[d]) mg[d][y][x] = v;
    endfunction

    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            bit nxt [8][8];
            int n;
            int nx;
            int ny;
            for (int y = 0; y < mrows[d]; y++) begin
                for (int x = 0; x < mcols[d]; x++) begin
                    n = 0;
                    for (int dy = -1; dy <= 1; dy++) begin
                        for (int dx = -1; dx <= 1; dx++) begin
                            if (dx == 0 && dy == 0) continue;
                            nx = x + dx;
                            ny = y + dy;
                            if (mwrap[d] != 0) begin
                                nx = (nx + mcols[d]) % mcols[d];
                                ny = (ny + mrows[d]) % mrows[d];
                            end else if (nx < 0 || ny < 0 || nx >= mcols[d] || ny >= mrows[d]) begin
                                continue;
                            end
                            if (mg[d][ny][nx]) n++;
                        end
                    end
                    nxt[y][x] = mg[d][y][x] ? msurv[d][4'(n)] : mbirth[d][4'(n)];
                end
            end
            for (int y = 0; y < mrows[d]; y++)
                for (int x = 0; x < mcols[d]; x++) mg[d][y][x] = nxt[y][x];
            exp_gen[d] = (exp_gen[d] + 1) % 65536;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, int observed, int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_gen(string tag);
        check({tag, " gen0"}, int'(gen0), exp_gen[0]);
        check({tag, " gen1"}, int'(gen1), exp_gen[1]);
    endtask

    // Read every cell (plus one off-grid row/column) through the pixel port.
    task automatic scan(string tag);
        int e0;
        int e1;
        for (int y = 0; y <= 8; y++) begin
            for (int x = 0; x <= 8; x++) begin
                VGAx = 10'(x * 16 + int'($urandom_range(0, 15)));
                VGAy = 10'(y * 16 + int'($urandom_range(0, 15)));
                tick();
                e0 = 0;
                e1 = 0;
                if (x < 8 && y < 8 && mg[0][y][x]) e0 = 7;
                if (x < 7 && y < 5 && mg[1][y][x]) e1 = 7;
                check($sformatf("%s rgb0(%0d,%0d)", tag, x, y), int'(rgb0), e0);
                check($sformatf("%s rgb1(%0d,%0d)", tag, x, y), int'(rgb1), e1);
            end
        end
    endtask

    task automatic reset_dut(string tag);
        clr = 1'b1;
        #2;
        check({tag, " busy0"}, int'(busy0), 0);
        check({tag, " busy1"}, int'(busy1), 0);
        check({tag, " gen0"}, int'(gen0), 0);
        check({tag, " gen1"}, int'(gen1), 0);
        check({tag, " rgb0"}, int'(rgb0), 0);
        tick();
        clr = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic write_cell(int x, int y, bit v);
        wr_x = 6'(x); wr_y = 6'(y); wr_val = v; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        model_write(x, y, v);
    endtask

    // Step pulse (optionally with a same-cycle write) and busy-length measurement.
    task automatic do_step(string tag, bit with_wr, int x, int y, bit v);
        int n0;
        int n1;
        step = 1'b1;
        if (with_wr) begin
            wr_x = 6'(x); wr_y = 6'(y); wr_val = v; wr_en = 1'b1;
            model_write(x, y, v);
        end
        tick();
        step = 1'b0;
        wr_en = 1'b0;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy0) n0++;
            if (busy1) n1++;
            if (!busy0 && !busy1) break;
            tick();
        end
        check({tag, " busy0 cycles"}, n0, 65);
        check({tag, " busy1 cycles"}, n1, 36);
        model_step();
        check_gen(tag);
    endtask

    task automatic vsync_gen();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (80) tick();
        model_step();
    endtask

    initial begin
        clr = 1'b1; vsync = 1'b0; run = 1'b0; step = 1'b0;
        wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_val = 1'b0;
        VGAx = '0; VGAy = '0;
        tick();
        reset_dut("por");
        scan("seed");

        // Pixel scaling around cell (1,0) and off-grid columns.
        VGAx = 10'd16;  VGAy = 10'd0;  tick(); check("pix16,0", int'(rgb0), 7);
        VGAx = 10'd31;  VGAy = 10'd15; tick(); check("pix31,15", int'(rgb0), 7);
        VGAx = 10'd15;  VGAy = 10'd0;  tick(); check("pix15,0", int'(rgb0), 0);
        VGAx = 10'd128; VGAy = 10'd0;  tick(); check("pix128", int'(rgb0), 0);
        VGAx = 10'd112; VGAy = 10'd16; tick(); check("pix112 u1", int'(rgb1), 0);

        // Blinker: vertical -> horizontal -> vertical.
        write_cell(3, 1, 1'b1); write_cell(3, 2, 1'b1); write_cell(3, 3, 1'b1);
        do_step("blink1", 1'b0, 0, 0, 1'b0);
        scan("blink1");
        do_step("blink2", 1'b0, 0, 0, 1'b0);
        scan("blink2");

        // Glider on the torus returns home after 32 vsync-triggered generations.
        reset_dut("glider");
        run = 1'b1;
        for (int i = 0; i < 32; i++) vsync_gen();
        run = 1'b0;
        check_gen("glider");
        scan("glider");

        // Dead border: corner block plus a lone cell on the edge.
        reset_dut("border");
        write_cell(5, 3, 1'b1); write_cell(6, 3, 1'b1);
        write_cell(5, 4, 1'b1); write_cell(6, 4, 1'b1); write_cell(6, 2, 1'b1);
        write_cell(7, 7, 1'b1);
        do_step("border", 1'b0, 0, 0, 1'b0);
        scan("border");

        // Random seeding with out-of-range writes and mixed triggers.
        for (int r = 0; r < 5; r++) begin
            for (int w = 0; w < 14; w++)
                write_cell(int'($urandom_range(0, 8)), int'($urandom_range(0, 8)), 1'($urandom));
            if (r == 2) begin
                do_step("wr+step", 1'b1, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), 1'b1);
            end else if ($urandom_range(0, 1) == 0) begin
                do_step("rand", 1'b0, 0, 0, 1'b0);
            end else begin
                run = 1'b1;
                vsync_gen();
                run = 1'b0;
                check_gen("rand vsync");
            end
            scan($sformatf("rand%0d", r));
        end

        // Busy handling: vsync dropped, step queued, write ignored during CALC.
        step = 1'b1; tick(); step = 1'b0;
        repeat (20) tick();
        run = 1'b1; vsync = 1'b1;
        repeat (2) tick();
        vsync = 1'b0;
        tick();
        run = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        wr_x = 6'd2; wr_y = 6'd2; wr_val = ~mg[0][2][2]; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        model_step();
        model_step();
        repeat (200) tick();
        check("busyh busy0", int'(busy0), 0);
        check("busyh busy1", int'(busy1), 0);
        check_gen("busyh");
        scan("busyh");

        // Reset in the middle of a generation restores the seed.
        step = 1'b1; tick(); step = 1'b0;
        repeat (10) tick();
        reset_dut("midcalc");
        scan("midcalc");
        do_step("after clr", 1'b0, 0, 0, 1'b0);
        scan("after clr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
